// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one of NREQ byte sources exclusive use of a UART TX buffer
// per message. Optional idle-owner timeout is enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned GAP     = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NREQ-1:0]     req_valid_i,
    input  logic [8*NREQ-1:0]   req_data_i,
    input  logic [NREQ-1:0]     req_last_i,
    output logic [NREQ-1:0]     req_ack_o,
    input  logic                buf_full_i,
    output logic                buf_data_ready_o,
    output logic [7:0]          buf_data_o,
    output logic [1:0]          grant_o,
    output logic                busy_o
);

    localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {StIdle, StOwn, StHold} state_e;

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic              last_q, last_d;
    logic              strobe_q, strobe_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [7:0]        data_q, data_d;

    logic              pick_valid;
    logic [1:0]        pick_idx;
    logic [1:0]        cand;
    logic              owner_valid;
    logic [7:0]        owner_byte;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
    logic [7:0] idle_q, idle_d;
`endif

    assign owner_valid = req_valid_i[grant_q];
    assign owner_byte  = req_data_i[{grant_q, 3'b000} +: 8];

    // First requesting index after the current owner; 2-bit add wraps modulo 4.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = grant_q;
        cand       = grant_q;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = grant_q + 2'(k);
            if (!pick_valid && req_valid_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gap_d    = gap_q;
        last_d   = last_q;
        strobe_d = 1'b0;
        ack_d    = '0;
        data_d   = data_q;
`ifdef UART_ARB_TIMEOUT_EN
        idle_d   = idle_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef UART_ARB_TIMEOUT_EN
                idle_d = '0;
`endif
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = StOwn;
                end
            end
            StOwn: begin
                if (owner_valid) begin
                    if (!buf_full_i && gap_q == '0) begin
                        strobe_d        = 1'b1;
                        data_d          = owner_byte;
                        ack_d[grant_q]  = 1'b1;
                        gap_d           = GapW'(GAP);
                        last_d          = req_last_i[grant_q];
                        state_d         = StHold;
`ifdef UART_ARB_TIMEOUT_EN
                        idle_d          = '0;
`endif
                    end
                end else begin
`ifdef UART_ARB_TIMEOUT_EN
                    // Owner went quiet mid-message: revoke so others are not starved.
                    if (idle_q == TimeoutCnt) begin
                        idle_d  = '0;
                        state_d = StIdle;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
`endif
                end
            end
            StHold: begin
                // Leave on the same edge the count hits zero: one byte per GAP+1 cycles.
                if (gap_q > GapW'(1)) begin
                    gap_d = gap_q - GapW'(1);
                end else begin
                    gap_d   = '0;
                    state_d = last_q ? StIdle : StOwn;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            grant_q  <= 2'd3;
            gap_q    <= '0;
            last_q   <= 1'b0;
            strobe_q <= 1'b0;
            ack_q    <= '0;
            data_q   <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gap_q    <= gap_d;
            last_q   <= last_d;
            strobe_q <= strobe_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
`ifdef UART_ARB_TIMEOUT_EN
            idle_q   <= idle_d;
`endif
        end
    end

    assign req_ack_o        = ack_q;
    assign buf_data_ready_o = strobe_q;
    assign buf_data_o       = data_q;
    assign grant_o          = grant_q;
    assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: byte sources advance on ack, every strobe is
// popped against the expected (owner, byte) queue, and per-scenario tasks check timing.
module tb_uart_tx_arbiter;

    localparam int unsigned Gap     = 2;
    localparam int unsigned Timeout = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        buf_full;
    logic [3:0]  req_ack;
    logic        buf_data_ready;
    logic [7:0]  buf_data;
    logic [1:0]  grant;
    logic        busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [7:0] exp_data[$];
    logic [1:0] exp_grant[$];

    logic [7:0] src_byte[4][8];
    logic       src_lst[4][8];
    int         src_len[4];
    int         src_ptr[4];

    int         n_stb;
    int         stb_cyc[16];
    logic [1:0] stb_who[16];

    uart_tx_arbiter #(
        .NREQ    (4),
        .GAP     (Gap),
        .TIMEOUT (Timeout)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_data_i       (req_data),
        .req_last_i       (req_last),
        .req_ack_o        (req_ack),
        .buf_full_i       (buf_full),
        .buf_data_ready_o (buf_data_ready),
        .buf_data_o       (buf_data),
        .grant_o          (grant),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        logic [7:0] ed;
        logic [1:0] eg;
        logic [3:0] ea;
        if (buf_data_ready) begin
            chk_cnt++;
            if (exp_data.size() == 0) begin
                $display("FAIL sb_unexpected_strobe: got data %02h grant %0d, want no strobe",
                         buf_data, grant);
            end else begin
                ed = exp_data.pop_front();
                eg = exp_grant.pop_front();
                ea = 4'b0001 << eg;
                if (buf_data !== ed || grant !== eg || req_ack !== ea)
                    $display("FAIL sb_strobe: got data %02h grant %0d ack %b, want %02h %0d %b",
                             buf_data, grant, req_ack, ed, eg, ea);
                else
                    pass_cnt++;
            end
        end else if (req_ack !== 4'b0000) begin
            chk_cnt++;
            $display("FAIL ack_without_strobe: got ack %b, want 0000", req_ack);
        end
    end

    task automatic drive_srcs();
        for (int i = 0; i < 4; i++) begin
            if (src_ptr[i] < src_len[i]) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = src_byte[i][src_ptr[i]];
                req_last[i]         = src_lst[i][src_ptr[i]];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < 4; i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
        end
        drive_srcs();
    endtask

    task automatic add_byte(input int i, input logic [7:0] b, input logic l);
        src_byte[i][src_len[i]] = b;
        src_lst[i][src_len[i]]  = l;
        src_len[i]++;
    endtask

    function automatic bit srcs_done();
        bit d = 1'b1;
        for (int i = 0; i < 4; i++)
            if (src_ptr[i] < src_len[i]) d = 1'b0;
        return d;
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        buf_full = 1'b0;
        clear_srcs();
        exp_data.delete();
        exp_grant.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycle numbers are posedges counted from the edge after stimulus is first applied.
    task automatic run(input int full_until, input int max_cyc, input bit expect_done);
        int   cyc;
        logic f;
        cyc   = 0;
        n_stb = 0;
        drive_srcs();
        buf_full = (full_until > 0);
        while (cyc < max_cyc && !(srcs_done() && !busy)) begin
            f = buf_full;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (buf_data_ready) begin
                if (n_stb < 16) begin
                    stb_cyc[n_stb] = cyc;
                    stb_who[n_stb] = grant;
                end
                n_stb++;
                chk_cnt++;
                if (f) $display("FAIL strobe_while_full: got strobe at cycle %0d, want none", cyc);
                else   pass_cnt++;
            end
            for (int i = 0; i < 4; i++)
                if (req_ack[i]) src_ptr[i]++;
            drive_srcs();
            buf_full = (cyc < full_until);
        end
        if (expect_done) begin
            chk_cnt++;
            if (!(srcs_done() && !busy))
                $display("FAIL run_timeout: got busy %0d after %0d cycles, want idle", busy, cyc);
            else
                pass_cnt++;
        end
        chk_cnt++;
        if (exp_data.size() != 0)
            $display("FAIL sb_drained: got %0d pending, want 0", exp_data.size());
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        buf_full  = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        clear_srcs();
        repeat (2) @(negedge clk);
        chk_cnt += 5;
        if (buf_data_ready !== 1'b0) $display("FAIL rst_strobe: got %b, want 0", buf_data_ready);
        else pass_cnt++;
        if (req_ack !== 4'b0000) $display("FAIL rst_ack: got %b, want 0000", req_ack);
        else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %b, want 0", busy);
        else pass_cnt++;
        if (buf_data !== 8'h00) $display("FAIL rst_data: got %02h, want 00", buf_data);
        else pass_cnt++;
        if (grant !== 2'd3) $display("FAIL rst_grant: got %0d, want 3", grant);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_single_msg();
        do_reset();
        add_byte(0, 8'h41, 1'b0);
        add_byte(0, 8'h42, 1'b1);
        exp_grant.push_back(2'd0); exp_data.push_back(8'h41);
        exp_grant.push_back(2'd0); exp_data.push_back(8'h42);
        run(0, 40, 1'b1);
        chk_cnt += 4;
        if (n_stb != 2) $display("FAIL single_count: got %0d, want 2", n_stb);
        else pass_cnt++;
        if (stb_cyc[0] != 2) $display("FAIL single_first_cycle: got %0d, want 2", stb_cyc[0]);
        else pass_cnt++;
        if (stb_cyc[1] != 5) $display("FAIL single_second_cycle: got %0d, want 5", stb_cyc[1]);
        else pass_cnt++;
        if (grant !== 2'd0) $display("FAIL single_grant: got %0d, want 0", grant);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            add_byte(i, 8'hA0 + 8'(i), 1'b1);
            exp_grant.push_back(2'(i));
            exp_data.push_back(8'hA0 + 8'(i));
        end
        run(0, 60, 1'b1);
        chk_cnt += 2;
        if (n_stb != 4) $display("FAIL rr_count: got %0d, want 4", n_stb);
        else pass_cnt++;
        // Each single-byte message costs one issue, GAP hold cycles and one arbitration cycle.
        if (stb_cyc[3] != 14) $display("FAIL rr_last_cycle: got %0d, want 14", stb_cyc[3]);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++;
            if (stb_who[k] !== 2'(k)) $display("FAIL rr_order: got %0d, want %0d", stb_who[k], k);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] want_who[4];
        int         want_cyc[4];
        want_who = '{2'd0, 2'd0, 2'd0, 2'd2};
        want_cyc = '{2, 5, 8, 12};
        clear_srcs();
        add_byte(0, 8'hC0, 1'b0);
        add_byte(0, 8'hC1, 1'b0);
        add_byte(0, 8'hC2, 1'b1);
        add_byte(2, 8'hD0, 1'b1);
        exp_grant.push_back(2'd0); exp_data.push_back(8'hC0);
        exp_grant.push_back(2'd0); exp_data.push_back(8'hC1);
        exp_grant.push_back(2'd0); exp_data.push_back(8'hC2);
        exp_grant.push_back(2'd2); exp_data.push_back(8'hD0);
        run(0, 60, 1'b1);
        chk_cnt++;
        if (n_stb != 4) $display("FAIL b2b_count: got %0d, want 4", n_stb);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++;
            if (stb_who[k] !== want_who[k] || stb_cyc[k] != want_cyc[k])
                $display("FAIL b2b_strobe%0d: got owner %0d cycle %0d, want %0d %0d",
                         k, stb_who[k], stb_cyc[k], want_who[k], want_cyc[k]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_buf_full();
        clear_srcs();
        add_byte(3, 8'hE3, 1'b1);
        exp_grant.push_back(2'd3); exp_data.push_back(8'hE3);
        run(10, 60, 1'b1);
        chk_cnt += 2;
        if (n_stb != 1) $display("FAIL full_count: got %0d, want 1", n_stb);
        else pass_cnt++;
        if (stb_cyc[0] != 11) $display("FAIL full_release_cycle: got %0d, want 11", stb_cyc[0]);
        else pass_cnt++;
    endtask

    task automatic test_reset_hold();
        bit seen;
        do_reset();
        add_byte(0, 8'hF0, 1'b0);
        add_byte(0, 8'hF1, 1'b1);
        add_byte(2, 8'hD2, 1'b1);
        exp_grant.push_back(2'd0); exp_data.push_back(8'hF0);
        drive_srcs();
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (req_ack[i]) src_ptr[i]++;
            seen = buf_data_ready;
            drive_srcs();
        end
        chk_cnt++;
        if (!seen) $display("FAIL rh_first_strobe: got none in 10 cycles, want one");
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt += 5;
        if (buf_data_ready !== 1'b0) $display("FAIL rh_strobe: got %b, want 0", buf_data_ready);
        else pass_cnt++;
        if (req_ack !== 4'b0000) $display("FAIL rh_ack: got %b, want 0000", req_ack);
        else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL rh_busy: got %b, want 0", busy);
        else pass_cnt++;
        if (buf_data !== 8'h00) $display("FAIL rh_data: got %02h, want 00", buf_data);
        else pass_cnt++;
        if (grant !== 2'd3) $display("FAIL rh_grant: got %0d, want 3", grant);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_grant.push_back(2'd0); exp_data.push_back(8'hF1);
        exp_grant.push_back(2'd2); exp_data.push_back(8'hD2);
        run(0, 60, 1'b1);
        chk_cnt += 2;
        if (stb_who[0] !== 2'd0 || stb_cyc[0] != 2)
            $display("FAIL rh_rearb: got owner %0d cycle %0d, want 0 2", stb_who[0], stb_cyc[0]);
        else
            pass_cnt++;
        if (stb_who[1] !== 2'd2) $display("FAIL rh_next_owner: got %0d, want 2", stb_who[1]);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_reset();
        add_byte(0, 8'h50, 1'b0);
        add_byte(1, 8'h51, 1'b1);
        exp_grant.push_back(2'd0); exp_data.push_back(8'h50);
`ifdef UART_ARB_TIMEOUT_EN
        exp_grant.push_back(2'd1); exp_data.push_back(8'h51);
        run(0, int'(Timeout) + 40, 1'b1);
        chk_cnt++;
        if (n_stb != 2 || stb_who[1] !== 2'd1)
            $display("FAIL to_handover: got %0d strobes owner %0d, want 2 1", n_stb, stb_who[1]);
        else
            pass_cnt++;
`else
        run(0, int'(Timeout) + 40, 1'b0);
        chk_cnt += 3;
        if (n_stb != 1) $display("FAIL to_count: got %0d, want 1", n_stb);
        else pass_cnt++;
        if (grant !== 2'd0) $display("FAIL to_grant_kept: got %0d, want 0", grant);
        else pass_cnt++;
        if (busy !== 1'b1) $display("FAIL to_busy: got %b, want 1", busy);
        else pass_cnt++;
`endif
        do_reset();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by 400000, want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_msg();
        test_round_robin();
        test_back_to_back();
        test_buf_full();
        test_reset_hold();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
